perf_counter_master: RTL and testbench

- Avalon-MM master that drives the 4-section performance-counter control slave from hardware event pulses, so sections can be timed without a CPU.
- Turns per-section start/stop pulses and a clear pulse into the slave's go/stop/reset writes.
- On request, reads every section's time and event counters back and streams them out as 32-bit words through a valid/ready port.
- Sits between the trigger logic (or a trace unit) and the counter slave on the system interconnect.

---
 rtl/perf_counter_master_pkg.sv | 43 ++++
 rtl/perf_counter_master_if.sv | 22 ++
 rtl/perf_counter_master_req_arbiter.sv | 107 ++++++++++
 rtl/perf_counter_master.sv | 174 +++++++++++++++++
 tb/tb_perf_counter_master.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/perf_counter_master_pkg.sv
// Shared constants, state and request encodings for the performance-counter master.
// The slave's register map is four words per section: time lo, time hi, event, control.
package perf_counter_pkg;

    localparam logic [3:0]  OFS_TIME_LO    = 4'd0;
    localparam logic [3:0]  OFS_TIME_HI    = 4'd1;
    localparam logic [3:0]  OFS_EVENT      = 4'd2;
    localparam logic [3:0]  SECTION_STRIDE = 4'd4;

    localparam logic [3:0]  STOP_OFS       = 4'd0;
    localparam logic [3:0]  GO_OFS         = 4'd1;
    localparam logic [31:0] CLR_DATA       = 32'd1;
    localparam logic [31:0] GO_STOP_DATA   = 32'd0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        RD    = 3'd2,
        RWAIT = 3'd3,
        OUT   = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        REQ_NONE  = 3'd0,
        REQ_CLR   = 3'd1,
        REQ_STOP  = 3'd2,
        REQ_START = 3'd3,
        REQ_SNAP  = 3'd4
    } req_kind_e;

    // Index of the lowest set bit; zero when nothing is set.
    function automatic logic [1:0] lowest_set(input logic [3:0] vec);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/perf_counter_master_if.sv
// Avalon-MM bus between the performance-counter master and the counter control slave.
interface perf_counter_master_if;

    logic [3:0]  avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata,
        output avm_waitrequest, avm_readdata, avm_readdatavalid
    );

endinterface

// File: rtl/perf_counter_master_req_arbiter.sv
// Sticky pending request bits, fixed-priority request selection and the
// saturating count of requests that were coalesced into an already-pending bit.
module perf_req_arbiter
    import perf_counter_pkg::*;
#(
    parameter int NUM_SECTIONS = 4,
    parameter int DROP_W       = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_SECTIONS-1:0] sec_start,
    input  logic [NUM_SECTIONS-1:0] sec_stop,
    input  logic                    clear_all,
    input  logic                    snap_req,
    input  logic                    accept,
    output req_kind_e               sel_kind,
    output logic [1:0]              sel_sec,
    output logic [DROP_W-1:0]       drop_cnt
);

    localparam int NREQ = 2 * NUM_SECTIONS + 2;

    logic [NUM_SECTIONS-1:0] start_pend_r;
    logic [NUM_SECTIONS-1:0] stop_pend_r;
    logic                    clr_pend_r;
    logic                    snap_pend_r;
    logic [DROP_W-1:0]       drop_cnt_r;

    req_kind_e               sel_kind_s;
    logic [1:0]              sel_sec_s;
    logic [NUM_SECTIONS-1:0] sel_onehot_s;
    logic [NUM_SECTIONS-1:0] start_clr_s;
    logic [NUM_SECTIONS-1:0] stop_clr_s;
    logic                    clr_clr_s;
    logic                    snap_clr_s;
    logic [NREQ-1:0]         drop_bits_s;
    logic [3:0]              drop_inc_s;
    logic [DROP_W:0]         drop_sum_s;

    // Fixed priority: clear, then stops, then starts (lowest section first), then snapshot.
    always_comb begin
        sel_kind_s = REQ_NONE;
        sel_sec_s  = 2'd0;
        if (clr_pend_r) begin
            sel_kind_s = REQ_CLR;
        end else if (|stop_pend_r) begin
            sel_kind_s = REQ_STOP;
            sel_sec_s  = lowest_set(4'(stop_pend_r));
        end else if (|start_pend_r) begin
            sel_kind_s = REQ_START;
            sel_sec_s  = lowest_set(4'(start_pend_r));
        end else if (snap_pend_r) begin
            sel_kind_s = REQ_SNAP;
        end else begin
            sel_kind_s = REQ_NONE;
        end
    end

    // Bits retired this cycle and the pulses that collide with a still-pending bit.
    always_comb begin
        sel_onehot_s = '0;
        for (int s = 0; s < NUM_SECTIONS; s++) begin
            sel_onehot_s[s] = (sel_sec_s == 2'(s));
        end
        clr_clr_s  = accept && (sel_kind_s == REQ_CLR);
        snap_clr_s = accept && (sel_kind_s == REQ_SNAP);
        // A global clear makes every outstanding go/stop obsolete.
        if (clr_clr_s) begin
            stop_clr_s  = '1;
            start_clr_s = '1;
        end else begin
            stop_clr_s  = (accept && (sel_kind_s == REQ_STOP))  ? sel_onehot_s : '0;
            start_clr_s = (accept && (sel_kind_s == REQ_START)) ? sel_onehot_s : '0;
        end
        drop_bits_s = {clear_all & clr_pend_r & ~clr_clr_s,
                       snap_req  & snap_pend_r & ~snap_clr_s,
                       sec_start & start_pend_r & ~start_clr_s,
                       sec_stop  & stop_pend_r  & ~stop_clr_s};
        drop_inc_s = 4'd0;
        for (int i = 0; i < NREQ; i++) begin
            drop_inc_s = drop_inc_s + {3'd0, drop_bits_s[i]};
        end
        drop_sum_s = {1'b0, drop_cnt_r} + (DROP_W+1)'(drop_inc_s);
    end

    // Pending bit and drop counter state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_pend_r <= '0;
            stop_pend_r  <= '0;
            clr_pend_r   <= 1'b0;
            snap_pend_r  <= 1'b0;
            drop_cnt_r   <= '0;
        end else begin
            start_pend_r <= (start_pend_r & ~start_clr_s) | sec_start;
            stop_pend_r  <= (stop_pend_r & ~stop_clr_s) | sec_stop;
            clr_pend_r   <= (clr_pend_r & ~clr_clr_s) | clear_all;
            snap_pend_r  <= (snap_pend_r & ~snap_clr_s) | snap_req;
            drop_cnt_r   <= drop_sum_s[DROP_W] ? '1 : drop_sum_s[DROP_W-1:0];
        end
    end

    assign sel_kind = sel_kind_s;
    assign sel_sec  = sel_sec_s;
    assign drop_cnt = drop_cnt_r;

endmodule

// File: rtl/perf_counter_master.sv
// Avalon-MM master that turns section start/stop/clear pulses into control writes
// and streams a full readback of every section's counters on request.
module perf_counter_master
    import perf_counter_pkg::*;
#(
    parameter int NUM_SECTIONS = 4,
    parameter int DROP_W       = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_SECTIONS-1:0]  sec_start,
    input  logic [NUM_SECTIONS-1:0]  sec_stop,
    input  logic                     clear_all,
    input  logic                     snap_req,
    output logic                     snap_busy,
    perf_counter_master_if.master    avm,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [31:0]              res_data,
    output logic [3:0]               res_index,
    output logic                     res_last,
    output logic [DROP_W-1:0]        drop_cnt
);

    localparam logic [3:0] LAST_BASE = 4'(int'(SECTION_STRIDE) * (NUM_SECTIONS - 1));

    state_e      state_r;
    logic [3:0]  avm_address_r;
    logic        avm_read_r;
    logic        avm_write_r;
    logic [31:0] avm_writedata_r;
    logic        res_valid_r;
    logic        res_last_r;
    logic [31:0] res_data_r;
    logic [3:0]  res_index_r;
    logic        snap_busy_r;
    logic [3:0]  base_r;
    logic [3:0]  ofs_r;

    req_kind_e   sel_kind_s;
    logic [1:0]  sel_sec_s;
    logic        accept_s;
    logic        last_word_s;

    perf_req_arbiter #(
        .NUM_SECTIONS (NUM_SECTIONS),
        .DROP_W       (DROP_W)
    ) u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .sec_start (sec_start),
        .sec_stop  (sec_stop),
        .clear_all (clear_all),
        .snap_req  (snap_req),
        .accept    (accept_s),
        .sel_kind  (sel_kind_s),
        .sel_sec   (sel_sec_s),
        .drop_cnt  (drop_cnt)
    );

    assign accept_s    = (state_r == IDLE) && (sel_kind_s != REQ_NONE);
    assign last_word_s = (base_r == LAST_BASE) && (ofs_r == OFS_EVENT);

    // Bus FSM: one write or one read in flight, result word held until consumed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= IDLE;
            avm_address_r   <= 4'd0;
            avm_read_r      <= 1'b0;
            avm_write_r     <= 1'b0;
            avm_writedata_r <= 32'd0;
            res_valid_r     <= 1'b0;
            res_last_r      <= 1'b0;
            res_data_r      <= 32'd0;
            res_index_r     <= 4'd0;
            snap_busy_r     <= 1'b0;
            base_r          <= 4'd0;
            ofs_r           <= 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    case (sel_kind_s)
                        REQ_CLR: begin
                            avm_write_r     <= 1'b1;
                            avm_address_r   <= 4'd0;
                            avm_writedata_r <= CLR_DATA;
                            state_r         <= WR;
                        end
                        REQ_STOP: begin
                            avm_write_r     <= 1'b1;
                            avm_address_r   <= {sel_sec_s, 2'b00} + STOP_OFS;
                            avm_writedata_r <= GO_STOP_DATA;
                            state_r         <= WR;
                        end
                        REQ_START: begin
                            avm_write_r     <= 1'b1;
                            avm_address_r   <= {sel_sec_s, 2'b00} + GO_OFS;
                            avm_writedata_r <= GO_STOP_DATA;
                            state_r         <= WR;
                        end
                        REQ_SNAP: begin
                            avm_read_r    <= 1'b1;
                            avm_address_r <= OFS_TIME_LO;
                            base_r        <= 4'd0;
                            ofs_r         <= OFS_TIME_LO;
                            snap_busy_r   <= 1'b1;
                            state_r       <= RD;
                        end
                        default: begin
                            state_r <= IDLE;
                        end
                    endcase
                end
                WR: begin
                    if (!avm.avm_waitrequest) begin
                        avm_write_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                RD: begin
                    if (!avm.avm_waitrequest) begin
                        avm_read_r <= 1'b0;
                        state_r    <= RWAIT;
                    end
                end
                RWAIT: begin
                    if (avm.avm_readdatavalid) begin
                        res_data_r  <= avm.avm_readdata;
                        res_index_r <= avm_address_r;
                        res_valid_r <= 1'b1;
                        res_last_r  <= last_word_s;
                        state_r     <= OUT;
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                        res_last_r  <= 1'b0;
                        if (res_last_r) begin
                            snap_busy_r <= 1'b0;
                            state_r     <= IDLE;
                        end else begin
                            // Sections are strided by four words; the control word is skipped.
                            if (ofs_r == OFS_EVENT) begin
                                base_r        <= base_r + SECTION_STRIDE;
                                ofs_r         <= OFS_TIME_LO;
                                avm_address_r <= base_r + SECTION_STRIDE;
                            end else begin
                                ofs_r         <= ofs_r + 4'd1;
                                avm_address_r <= base_r + ofs_r + 4'd1;
                            end
                            avm_read_r <= 1'b1;
                            state_r    <= RD;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign avm.avm_address   = avm_address_r;
    assign avm.avm_read      = avm_read_r;
    assign avm.avm_write     = avm_write_r;
    assign avm.avm_writedata = avm_writedata_r;
    assign res_valid         = res_valid_r;
    assign res_last          = res_last_r;
    assign res_data          = res_data_r;
    assign res_index         = res_index_r;
    assign snap_busy         = snap_busy_r;

endmodule

// File: tb/tb_perf_counter_master.sv
// Directed bench for perf_counter_master: control writes, coalescing, snapshots
// with back-pressure, and reset in the middle of a read.
module tb_perf_counter_master;

    typedef struct packed {
        logic [3:0]  a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  sec_start = 4'd0;
    logic [3:0]  sec_stop = 4'd0;
    logic        clear_all = 1'b0;
    logic        snap_req = 1'b0;
    logic        snap_busy;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [31:0] res_data;
    logic [3:0]  res_index;
    logic        res_last;
    logic [15:0] drop_cnt;
    logic        waitreq = 1'b0;
    logic        rdv_r = 1'b0;
    logic [31:0] rdata_r = 32'd0;
    wr_t         wr_log[$];
    int          rd_count = 0;
    int          chk_cnt = 0;
    int          pass_cnt = 0;
    logic [3:0]  exp_idx [12] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6,
                                  4'd8, 4'd9, 4'd10, 4'd12, 4'd13, 4'd14};

    perf_counter_master_if bus ();

    perf_counter_master #(.NUM_SECTIONS(4), .DROP_W(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sec_start (sec_start),
        .sec_stop  (sec_stop),
        .clear_all (clear_all),
        .snap_req  (snap_req),
        .snap_busy (snap_busy),
        .avm       (bus.master),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_index (res_index),
        .res_last  (res_last),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    assign bus.avm_waitrequest   = waitreq;
    assign bus.avm_readdatavalid = rdv_r;
    assign bus.avm_readdata      = rdata_r;

    // Slave: data returns one cycle after an accepted read.
    always @(posedge clk) begin
        if (bus.avm_read && !bus.avm_waitrequest) begin
            rdv_r   <= 1'b1;
            rdata_r <= 32'hC0DE_0000 | {28'd0, bus.avm_address};
        end else begin
            rdv_r   <= 1'b0;
            rdata_r <= 32'hDEAD_BEEF;
        end
    end

    // Bus monitor: accepted writes and reads.
    always @(posedge clk) begin
        if (reset_n && bus.avm_write && !bus.avm_waitrequest)
            wr_log.push_back({bus.avm_address, bus.avm_writedata});
        if (reset_n && bus.avm_read && !bus.avm_waitrequest)
            rd_count <= rd_count + 1;
    end

    function automatic wr_t log_at(input int i);
        return (wr_log.size() > i) ? wr_log[i] : wr_t'('1);
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_cnt++; if ({bus.avm_write, bus.avm_read, bus.avm_address} !== 6'd0) $display("FAIL reset_bus: got %0h want 0", {bus.avm_write, bus.avm_read, bus.avm_address}); else pass_cnt++;
        chk_cnt++; if ({res_valid, res_last, snap_busy} !== 3'd0) $display("FAIL reset_flags: got %0h want 0", {res_valid, res_last, snap_busy}); else pass_cnt++;
        chk_cnt++; if ({res_data, res_index} !== 36'd0) $display("FAIL reset_res: got %0h want 0", {res_data, res_index}); else pass_cnt++;
        chk_cnt++; if (drop_cnt !== 16'd0) $display("FAIL reset_drop: got %0d want 0", drop_cnt); else pass_cnt++;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        int hi;
        wr_log.delete();
        sec_start = 4'b0100;
        @(negedge clk);
        sec_start = 4'b0000;
        hi = 0;
        repeat (8) begin
            if (bus.avm_write) hi++;
            @(negedge clk);
        end
        chk_cnt++; if (hi !== 1) $display("FAIL single_len: got %0d cycles want 1", hi); else pass_cnt++;
        chk_cnt++; if (wr_log.size() !== 1) $display("FAIL single_count: got %0d want 1", wr_log.size()); else pass_cnt++;
        chk_cnt++; if (log_at(0) !== {4'd9, 32'd0}) $display("FAIL single_write: got %0h want %0h", log_at(0), {4'd9, 32'd0}); else pass_cnt++;
        chk_cnt++; if (drop_cnt !== 16'd0) $display("FAIL single_drop: got %0d want 0", drop_cnt); else pass_cnt++;
    endtask

    task automatic test_stop_start_clr();
        wr_log.delete();
        sec_stop  = 4'b0010;
        sec_start = 4'b0010;
        @(negedge clk);
        sec_stop  = 4'b0000;
        sec_start = 4'b0000;
        clear_all = 1'b1;
        @(negedge clk);
        clear_all = 1'b0;
        repeat (12) @(negedge clk);
        chk_cnt++; if (wr_log.size() !== 2) $display("FAIL ssc_count: got %0d want 2", wr_log.size()); else pass_cnt++;
        chk_cnt++; if (log_at(0) !== {4'd4, 32'd0}) $display("FAIL ssc_first: got %0h want %0h", log_at(0), {4'd4, 32'd0}); else pass_cnt++;
        chk_cnt++; if (log_at(1) !== {4'd0, 32'd1}) $display("FAIL ssc_second: got %0h want %0h", log_at(1), {4'd0, 32'd1}); else pass_cnt++;
    endtask

    task automatic run_snapshot(input int stall_word, input bit check_lat);
        int lat, words, budget, rc;
        logic [31:0] d0;
        logic [3:0] i0;
        res_ready = 1'b1;
        snap_req  = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        lat = 1;
        while (!res_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (check_lat) begin
            chk_cnt++; if (lat !== 4) $display("FAIL snap_latency: got %0d want 4", lat); else pass_cnt++;
        end
        chk_cnt++; if (snap_busy !== 1'b1) $display("FAIL snap_busy_high: got %0b want 1", snap_busy); else pass_cnt++;
        words = 0;
        budget = 0;
        while (words < 12 && budget < 400) begin
            if (res_valid) begin
                if (words == stall_word) begin
                    res_ready = 1'b0;
                    rc = rd_count;
                    d0 = res_data;
                    i0 = res_index;
                    repeat (10) begin
                        @(negedge clk);
                        chk_cnt++; if ({res_valid, res_data, res_index, rd_count} !== {1'b1, d0, i0, rc}) $display("FAIL stall_hold: got v%0b d%0h i%0d r%0d want v1 d%0h i%0d r%0d", res_valid, res_data, res_index, rd_count, d0, i0, rc); else pass_cnt++;
                    end
                    res_ready = 1'b1;
                end
                chk_cnt++; if (res_index !== exp_idx[words]) $display("FAIL snap_index: got %0d want %0d", res_index, exp_idx[words]); else pass_cnt++;
                chk_cnt++; if (res_data !== (32'hC0DE_0000 | {28'd0, exp_idx[words]})) $display("FAIL snap_data: got %0h want %0h", res_data, 32'hC0DE_0000 | {28'd0, exp_idx[words]}); else pass_cnt++;
                chk_cnt++; if (res_last !== (words == 11)) $display("FAIL snap_last: got %0b want %0b at word %0d", res_last, words == 11, words); else pass_cnt++;
                words++;
            end
            @(negedge clk);
            budget++;
        end
        chk_cnt++; if (words !== 12) $display("FAIL snap_words: got %0d want 12", words); else pass_cnt++;
        chk_cnt++; if ({snap_busy, res_valid} !== 2'b00) $display("FAIL snap_busy_low: got %0b want 00", {snap_busy, res_valid}); else pass_cnt++;
    endtask

    task automatic test_stall_drop();
        wr_log.delete();
        waitreq = 1'b1;
        sec_start = 4'b1000;
        @(negedge clk);
        sec_start = 4'b0000;
        @(negedge clk);
        for (int c = 0; c < 20; c++) begin
            sec_start = (c == 2 || c == 5 || c == 8) ? 4'b0001 : 4'b0000;
            chk_cnt++; if ({bus.avm_write, bus.avm_address, bus.avm_writedata} !== {1'b1, 4'd13, 32'd0}) $display("FAIL stall_stable: got w%0b a%0d d%0h want w1 a13 d0", bus.avm_write, bus.avm_address, bus.avm_writedata); else pass_cnt++;
            @(negedge clk);
        end
        sec_start = 4'b0000;
        waitreq = 1'b0;
        repeat (12) @(negedge clk);
        chk_cnt++; if (wr_log.size() !== 2) $display("FAIL stall_count: got %0d want 2", wr_log.size()); else pass_cnt++;
        chk_cnt++; if (log_at(0) !== {4'd13, 32'd0}) $display("FAIL stall_first: got %0h want %0h", log_at(0), {4'd13, 32'd0}); else pass_cnt++;
        chk_cnt++; if (log_at(1) !== {4'd1, 32'd0}) $display("FAIL stall_second: got %0h want %0h", log_at(1), {4'd1, 32'd0}); else pass_cnt++;
        chk_cnt++; if (drop_cnt !== 16'd2) $display("FAIL stall_drop: got %0d want 2", drop_cnt); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        wr_log.delete();
        res_ready = 1'b1;
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        sec_start = 4'b0100;
        @(negedge clk);
        sec_start = 4'b0000;
        chk_cnt++; if ({bus.avm_read, bus.avm_address} !== {1'b1, 4'd0}) $display("FAIL mid_read: got r%0b a%0d want r1 a0", bus.avm_read, bus.avm_address); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if ({snap_busy, bus.avm_read} !== 2'b10) $display("FAIL mid_rwait: got %0b want 10", {snap_busy, bus.avm_read}); else pass_cnt++;
        reset_n = 1'b0;
        #1;
        chk_cnt++; if ({bus.avm_write, bus.avm_read, bus.avm_address, bus.avm_writedata} !== 38'd0) $display("FAIL mid_bus: got %0h want 0", {bus.avm_write, bus.avm_read, bus.avm_address, bus.avm_writedata}); else pass_cnt++;
        chk_cnt++; if ({res_valid, res_last, snap_busy, res_data, res_index} !== 39'd0) $display("FAIL mid_res: got %0h want 0", {res_valid, res_last, snap_busy, res_data, res_index}); else pass_cnt++;
        chk_cnt++; if (drop_cnt !== 16'd0) $display("FAIL mid_drop: got %0d want 0", drop_cnt); else pass_cnt++;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk_cnt++; if (wr_log.size() !== 0) $display("FAIL mid_pending: got %0d writes want 0", wr_log.size()); else pass_cnt++;
        chk_cnt++; if ({res_valid, snap_busy} !== 2'b00) $display("FAIL mid_idle: got %0b want 00", {res_valid, snap_busy}); else pass_cnt++;
        run_snapshot(-1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_stop_start_clr();
        run_snapshot(-1, 1'b1);
        run_snapshot(3, 1'b0);
        test_stall_drop();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
